// File: rtl/game_event_source.sv
// Producer side of the game event handshake: key press / autorepeat / gravity
// triggers become sticky per-bit requests that the game core retires by acking.
`ifndef EVENT_KEY_UP
`define EVENT_KEY_UP 0
`endif
`ifndef EVENT_KEY_DOWN
`define EVENT_KEY_DOWN 1
`endif
`ifndef EVENT_KEY_LEFT
`define EVENT_KEY_LEFT 2
`endif
`ifndef EVENT_KEY_RIGHT
`define EVENT_KEY_RIGHT 3
`endif
`ifndef EVENT_KEY_SPACE
`define EVENT_KEY_SPACE 4
`endif
`ifndef EVENT_FALL
`define EVENT_FALL 5
`endif

module game_event_source #(
  parameter int EVENT_LEN     = 6,
  parameter int LEVEL_LEN     = 4,
  parameter int FALL_STEP     = 768,
  parameter int REPEAT_DELAY  = 2400,
  parameter int REPEAT_PERIOD = 600
) (
  input  logic                 main_clk,
  input  logic                 rst_1plus,
  input  logic [4:0]           key_down,
  input  logic [LEVEL_LEN-1:0] level,
  input  logic                 fall_en,
  input  logic [EVENT_LEN-1:0] event_received,
  output logic [EVENT_LEN-1:0] event_out,
  output logic [7:0]           drop_cnt
);

  localparam logic [12:0] C_DELAY = 13'(REPEAT_DELAY);
  // The increment still applies on the reload cycle, so later repeats land
  // exactly REPEAT_PERIOD cycles apart.
  localparam logic [12:0] C_RELOAD = 13'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  logic [4:0]           r_s1;
  logic [4:0]           r_s2;
  logic [4:0]           r_prev;
  logic [4:0]           w_press;
  logic [2:0]           w_rep;
  logic [15:0]          r_fall_cnt;
  logic [15:0]          w_steps;
  logic [15:0]          w_period;
  logic                 w_fall;
  logic [EVENT_LEN-1:0] w_trig;
  logic [EVENT_LEN-1:0] w_lost;
  logic [EVENT_LEN-1:0] r_event;
  logic [7:0]           r_drop;

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_prev <= '0;
    end else begin
      r_s1   <= key_down;
      r_s2   <= r_s1;
      r_prev <= r_s2;
    end
  end

  assign w_press = r_s2 & ~r_prev;

  // Autorepeat for DOWN, LEFT, RIGHT (key indices 1..3).
  for (genvar g = 0; g < 3; g++) begin : g_rep
    logic [12:0] r_hold;

    assign w_rep[g] = r_s2[g+1] && (r_hold == C_DELAY);

    always_ff @(posedge main_clk or posedge rst_1plus) begin
      if (rst_1plus) begin
        r_hold <= '0;
      end else if (!r_s2[g+1] || w_press[g+1]) begin
        r_hold <= '0;
      end else if (w_rep[g]) begin
        r_hold <= C_RELOAD;
      end else begin
        r_hold <= r_hold + 13'd1;
      end
    end
  end

  assign w_steps  = 16'd16 - 16'(level);
  assign w_period = w_steps * 16'(FALL_STEP);
  // Compare with >= so a level increase mid-count fires instead of wrapping.
  assign w_fall   = fall_en && (r_fall_cnt >= (w_period - 16'd1));

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      r_fall_cnt <= '0;
    end else if (!fall_en || w_fall) begin
      r_fall_cnt <= '0;
    end else begin
      r_fall_cnt <= r_fall_cnt + 16'd1;
    end
  end

  always_comb begin
    w_trig                   = '0;
    w_trig[`EVENT_KEY_UP]    = w_press[0];
    w_trig[`EVENT_KEY_DOWN]  = w_press[1] | w_rep[0];
    w_trig[`EVENT_KEY_LEFT]  = w_press[2] | w_rep[1];
    w_trig[`EVENT_KEY_RIGHT] = w_press[3] | w_rep[2];
    w_trig[`EVENT_KEY_SPACE] = w_press[4];
    w_trig[`EVENT_FALL]      = w_fall;
  end

  assign w_lost = w_trig & r_event & ~event_received;

  always_ff @(posedge main_clk or posedge rst_1plus) begin
    if (rst_1plus) begin
      r_event <= '0;
      r_drop  <= '0;
    end else begin
      r_event <= w_trig | (r_event & ~event_received);
      if ((|w_lost) && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  assign event_out = r_event;
  assign drop_cnt  = r_drop;

endmodule

// File: tb/tb_game_event_source.sv
// Directed bench for game_event_source with short timers
// (FALL_STEP=4, REPEAT_DELAY=8, REPEAT_PERIOD=3).
module tb_game_event_source;

  logic       main_clk = 1'b0;
  logic       rst_1plus;
  logic [4:0] key_down;
  logic [3:0] level;
  logic       fall_en;
  logic [5:0] event_received;
  logic [5:0] event_out;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 main_clk = ~main_clk;

  game_event_source #(
    .EVENT_LEN(6), .LEVEL_LEN(4), .FALL_STEP(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3)
  ) dut (
    .main_clk(main_clk), .rst_1plus(rst_1plus), .key_down(key_down), .level(level),
    .fall_en(fall_en), .event_received(event_received), .event_out(event_out),
    .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic [4:0] key;
    logic [5:0] ack;
    logic [5:0] exp_ev;
    logic [7:0] exp_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [4:0] k, input logic [5:0] a, input logic [5:0] e,
                     input logic [7:0] d);
    vec_t v;
    v.key = k; v.ack = a; v.exp_ev = e; v.exp_drop = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge main_clk);
    @(negedge main_clk);
  endtask

  // Hold key k, release before edge n_hold+1, run n_total edges checking the
  // whole event vector; press lands on edge 3, repeats at 12,15,... up to last_rep.
  task automatic run_hold(input int k, input int ev_bit, input bit rep, input int n_hold,
                          input int n_total, input int last_rep, input string name);
    logic [5:0] exp;
    key_down    = 5'b0;
    key_down[k] = 1'b1;
    for (int j = 1; j <= n_total; j++) begin
      if (j == n_hold + 1) key_down = 5'b0;
      tick();
      exp = '0;
      if (j == 3 || (rep && j >= 12 && j <= last_rep && ((j - 12) % 3) == 0))
        exp = 6'b1 << ev_bit;
      check(name, event_out, exp);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int first_set;

    // key, ack, expected event_out, expected drop_cnt
    add(5'b00001, 6'b000000, 6'b000000, 8'd0);
    add(5'b00001, 6'b000000, 6'b000000, 8'd0);
    add(5'b00001, 6'b000000, 6'b000001, 8'd0);
    add(5'b00001, 6'b000000, 6'b000001, 8'd0);
    add(5'b00001, 6'b000000, 6'b000001, 8'd0);
    add(5'b00001, 6'b000001, 6'b000000, 8'd0);
    add(5'b00001, 6'b000000, 6'b000000, 8'd0);
    add(5'b10001, 6'b000000, 6'b000000, 8'd0);
    add(5'b10001, 6'b000000, 6'b000000, 8'd0);
    add(5'b10001, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b11000, 6'b010000, 6'b000000, 8'd0);
    add(5'b11000, 6'b000000, 6'b000000, 8'd0);
    add(5'b11000, 6'b000000, 6'b001000, 8'd0);
    add(5'b00000, 6'b001000, 6'b000000, 8'd0);
    add(5'b00000, 6'b000000, 6'b000000, 8'd0);
    add(5'b00000, 6'b000000, 6'b000000, 8'd0);
    add(5'b00000, 6'b000000, 6'b000000, 8'd0);
    add(5'b10000, 6'b000000, 6'b000000, 8'd0);
    add(5'b10000, 6'b000000, 6'b000000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b00000, 6'b000000, 6'b010000, 8'd0);
    add(5'b00000, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd0);
    add(5'b10000, 6'b000000, 6'b010000, 8'd1);
    add(5'b10000, 6'b010000, 6'b000000, 8'd1);

    // Reset with UP held
    rst_1plus      = 1'b1;
    key_down       = 5'b00001;
    level          = 4'd0;
    fall_en        = 1'b0;
    event_received = '0;
    tick(); tick(); tick();
    check("reset_event", event_out, 6'b0);
    check("reset_drop", drop_cnt, 8'd0);
    rst_1plus = 1'b0;

    foreach (vecs[i]) begin
      key_down       = vecs[i].key;
      event_received = vecs[i].ack;
      tick();
      check($sformatf("vec%0d_event", i), event_out, vecs[i].exp_ev);
      check($sformatf("vec%0d_drop", i), drop_cnt, vecs[i].exp_drop);
    end

    // Gravity at level 15: triggers on F3, F7, F11, ...
    key_down       = 5'b0;
    event_received = '0;
    level          = 4'd15;
    fall_en        = 1'b1;
    tick(); tick(); tick();
    check("fall_before_first", event_out[5], 1'b0);
    tick();
    check("fall_first", event_out, 6'b100000);
    check("fall_first_drop", drop_cnt, 8'd1);
    tick(); tick(); tick();
    event_received = 6'b100000;
    tick();
    check("ack_with_trig_event", event_out[5], 1'b1);
    check("ack_with_trig_drop", drop_cnt, 8'd1);
    event_received = '0;
    tick();
    check("pending_after_simul", event_out[5], 1'b1);
    event_received = 6'b100000;
    tick();
    check("second_ack_clears", event_out[5], 1'b0);
    event_received = '0;
    tick(); tick();
    check("fall_rearm", event_out[5], 1'b1);
    check("fall_rearm_drop", drop_cnt, 8'd1);
    for (int k = 1; k <= 260; k++) begin
      tick(); tick(); tick(); tick();
      check($sformatf("drop_sat_%0d", k), drop_cnt, (k + 1 > 255) ? 8'd255 : 8'(k + 1));
    end

    event_received = 6'b100000;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check($sformatf("fall_pulse_%0d", j), event_out[5], (j % 4) == 0);
    end

    // Level 0: period 64
    level     = 4'd0;
    first_set = 0;
    for (int j = 1; j <= 64; j++) begin
      tick();
      if (first_set == 0 && event_out[5]) first_set = j;
    end
    check("fall_level0_period", first_set, 64);

    // Level raise mid-count: fall_cnt reaches 40 at level 0, then level 15
    for (int j = 1; j <= 40; j++) tick();
    check("level_mid_idle", event_out[5], 1'b0);
    level = 4'd15;
    tick();
    check("level_raise_fires", event_out[5], 1'b1);
    tick(); tick(); tick();
    check("level_restart_pre", event_out[5], 1'b0);
    tick();
    check("level_restart_fire", event_out[5], 1'b1);

    // Autorepeat with an ack every cycle
    fall_en        = 1'b0;
    event_received = 6'b111111;
    tick();
    check("clear_before_rep", event_out, 6'b0);
    run_hold(2, 2, 1'b1, 29, 45, 30, "left_repeat");
    run_hold(0, 0, 1'b0, 29, 45, 30, "up_no_repeat");

    // Mid-operation reset
    rst_1plus = 1'b1;
    #1;
    check("rst_async_drop", drop_cnt, 8'd0);
    tick();
    rst_1plus      = 1'b0;
    level          = 4'd15;
    fall_en        = 1'b1;
    key_down       = 5'b00010;
    event_received = 6'b000010;
    for (int j = 1; j <= 25; j++) tick();
    check("pre_rst_drop", drop_cnt, 8'd5);
    check("pre_rst_event", event_out, 6'b100000);
    rst_1plus = 1'b1;
    fall_en   = 1'b0;
    #1;
    check("mid_rst_event", event_out, 6'b0);
    check("mid_rst_drop", drop_cnt, 8'd0);
    tick(); tick();
    check("mid_rst_held", event_out, 6'b0);
    rst_1plus = 1'b0;
    run_hold(1, 1, 1'b1, 13, 13, 13, "down_after_rst");
    check("down_after_rst_drop", drop_cnt, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
